cla_adder_sequencer: RTL and testbench

Multi-cycle wide-operand adder controller. Accepts a WORD_WIDTH*WORD_COUNT-bit addition through a valid/ready handshake. Executes it over WORD_COUNT cycles on a single WORD_WIDTH-bit ClaAdder instance, chaining the carry through a register. Presents the full result through a second valid/ready handshake, so wide additions cost narrow-adder area in the arithmetic datapath.

---
 rtl/cla_pkg.sv | 23 ++
 rtl/cla_adder_sequencer_cla_adder.sv | 50 +++++
 rtl/cla_adder_sequencer.sv | 152 +++++++++++++++
 tb/tb_cla_adder_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// ============================================================================
// Module : cla_pkg
// Brief  : Shared types and helpers for ClaAdder-based controllers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } cla_seq_state_t;

    // Index register width; a single-entry index still needs one bit.
    function automatic int cla_index_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cla_adder_sequencer_cla_adder.sv
// ============================================================================
// Module : ClaAdder
// Brief  : Combinational carry-lookahead adder slice with carry-in/carry-out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ClaAdder #(
    parameter int INPUT_BIT_WIDTH = 8
) (
    input  logic [INPUT_BIT_WIDTH-1:0] InputA,
    input  logic [INPUT_BIT_WIDTH-1:0] InputB,
    input  logic                       InputCarry,
    output logic [INPUT_BIT_WIDTH-1:0] Sum,
    output logic                       OutputCarry
);

    logic [INPUT_BIT_WIDTH-1:0] w_gen;
    logic [INPUT_BIT_WIDTH-1:0] w_prop;
    logic [INPUT_BIT_WIDTH:0]   w_carry;
    logic                       w_acc;
    logic                       w_chain;

    assign w_gen  = InputA & InputB;
    assign w_prop = InputA ^ InputB;

    // Each carry is the flat sum-of-products of all lower generates, so no
    // carry depends on another carry.
    always_comb begin
        w_carry    = '0;
        w_acc      = 1'b0;
        w_chain    = 1'b0;
        w_carry[0] = InputCarry;
        for (int i = 0; i < INPUT_BIT_WIDTH; i++) begin
            w_acc   = w_gen[i];
            w_chain = w_prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_acc   = w_acc | (w_chain & w_gen[j]);
                w_chain = w_chain & w_prop[j];
            end
            w_carry[i+1] = w_acc | (w_chain & InputCarry);
        end
    end

    assign Sum         = w_prop ^ w_carry[INPUT_BIT_WIDTH-1:0];
    assign OutputCarry = w_carry[INPUT_BIT_WIDTH];

endmodule

`default_nettype wire

// File: rtl/cla_adder_sequencer.sv
// ============================================================================
// Module : cla_adder_sequencer
// Brief  : Wide adder executed slice-by-slice on one shared ClaAdder, with
//          valid/ready handshakes on input and result.
//          Optional macro CLA_SEQ_SUBTRACT_EN adds a Subtract input (A-B).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_adder_sequencer
    import cla_pkg::*;
#(
    parameter  int WORD_WIDTH  = 8,
    parameter  int WORD_COUNT  = 4,
    localparam int TOTAL_WIDTH = WORD_WIDTH * WORD_COUNT
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [TOTAL_WIDTH-1:0] InputA,
    input  logic [TOTAL_WIDTH-1:0] InputB,
    input  logic                   InputCarry,
`ifdef CLA_SEQ_SUBTRACT_EN
    input  logic                   Subtract,
`endif
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [TOTAL_WIDTH-1:0] Sum,
    output logic                   OutputCarry,
    output logic                   Busy
);

    localparam int              IDX_W    = cla_index_width(WORD_COUNT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_COUNT - 1);

    cla_seq_state_t         state_q, state_d;
    logic [TOTAL_WIDTH-1:0] a_q, a_d;
    logic [TOTAL_WIDTH-1:0] b_q, b_d;
    logic [TOTAL_WIDTH-1:0] sum_q, sum_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   carry_q, carry_d;
    logic                   cout_q, cout_d;

    logic [WORD_WIDTH-1:0]  w_a_slice;
    logic [WORD_WIDTH-1:0]  w_b_slice;
    logic [WORD_WIDTH-1:0]  w_slice_sum;
    logic                   w_slice_cout;
    logic [TOTAL_WIDTH-1:0] w_b_in;
    logic                   w_carry_in;

`ifdef CLA_SEQ_SUBTRACT_EN
    // Subtraction is A + ~B + 1; inverting at capture keeps the datapath shared.
    assign w_b_in     = Subtract ? ~InputB : InputB;
    assign w_carry_in = Subtract ? 1'b1 : InputCarry;
`else
    assign w_b_in     = InputB;
    assign w_carry_in = InputCarry;
`endif

    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int k = 0; k < WORD_COUNT; k++) begin
            if (idx_q == IDX_W'(k)) begin
                w_a_slice = a_q[k*WORD_WIDTH +: WORD_WIDTH];
                w_b_slice = b_q[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    ClaAdder #(
        .INPUT_BIT_WIDTH(WORD_WIDTH)
    ) u_cla_adder (
        .InputA     (w_a_slice),
        .InputB     (w_b_slice),
        .InputCarry (carry_q),
        .Sum        (w_slice_sum),
        .OutputCarry(w_slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (InValid) begin
                    a_d     = InputA;
                    b_d     = w_b_in;
                    carry_d = w_carry_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = w_slice_cout;
                for (int k = 0; k < WORD_COUNT; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[k*WORD_WIDTH +: WORD_WIDTH] = w_slice_sum;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    cout_d  = w_slice_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign InReady     = (state_q == IDLE);
    assign OutValid    = (state_q == DONE);
    assign Busy        = (state_q != IDLE);
    assign Sum         = sum_q;
    assign OutputCarry = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_adder_sequencer.sv
// ============================================================================
// Module : tb_cla_adder_sequencer
// Brief  : Self-checking bench for cla_adder_sequencer (default and
//          CLA_SEQ_SUBTRACT_EN builds), plus a single-slice instance.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cla_adder_sequencer;

    localparam int WW = 8;
    localparam int WC = 4;
    localparam int TW = WW * WC;

    logic          Clock      = 1'b0;
    logic          ResetN     = 1'b0;
    logic          InValid    = 1'b0;
    logic          InputCarry = 1'b0;
    logic          OutReady   = 1'b1;
    logic [TW-1:0] InputA     = '0;
    logic [TW-1:0] InputB     = '0;
    logic          InReady, OutValid, OutputCarry, Busy;
    logic [TW-1:0] Sum;
`ifdef CLA_SEQ_SUBTRACT_EN
    logic          Subtract   = 1'b0;
    logic          s_subtract = 1'b0;
`endif

    logic       s_in_valid  = 1'b0;
    logic       s_out_ready = 1'b1;
    logic       s_cin       = 1'b0;
    logic [7:0] s_a         = '0;
    logic [7:0] s_b         = '0;
    logic       s_in_ready, s_out_valid, s_cout, s_busy;
    logic [7:0] s_sum;

    int n_pass    = 0;
    int n_total   = 0;
    int n_accepts = 0;

    always #5 Clock = ~Clock;

    cla_adder_sequencer #(.WORD_WIDTH(WW), .WORD_COUNT(WC)) dut (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .InValid    (InValid),
        .InReady    (InReady),
        .InputA     (InputA),
        .InputB     (InputB),
        .InputCarry (InputCarry),
`ifdef CLA_SEQ_SUBTRACT_EN
        .Subtract   (Subtract),
`endif
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .Sum        (Sum),
        .OutputCarry(OutputCarry),
        .Busy       (Busy)
    );

    cla_adder_sequencer #(.WORD_WIDTH(8), .WORD_COUNT(1)) dut_single (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .InValid    (s_in_valid),
        .InReady    (s_in_ready),
        .InputA     (s_a),
        .InputB     (s_b),
        .InputCarry (s_cin),
`ifdef CLA_SEQ_SUBTRACT_EN
        .Subtract   (s_subtract),
`endif
        .OutValid   (s_out_valid),
        .OutReady   (s_out_ready),
        .Sum        (s_sum),
        .OutputCarry(s_cout),
        .Busy       (s_busy)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Reference: full-width arithmetic, with the visible Sum growing one
    // slice per cycle and the handshake timing derived from WC.
    int            m_mode = 0;   // 0 waiting, 1 computing, 2 presenting
    int            m_cnt  = 0;
    logic [TW:0]   m_full = '0;
    logic [TW-1:0] m_sum  = '0;
    logic          m_cout = 1'b0;
    logic [TW:0]   m_one  = 1;

    always @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            m_mode = 0;
            m_cnt  = 0;
            m_sum  = '0;
            m_cout = 1'b0;
        end else begin
            case (m_mode)
                0: if (InValid) begin
`ifdef CLA_SEQ_SUBTRACT_EN
                    if (Subtract) m_full = {1'b0, InputA} + {1'b0, ~InputB} + 1;
                    else          m_full = {1'b0, InputA} + {1'b0, InputB} + InputCarry;
`else
                    m_full = {1'b0, InputA} + {1'b0, InputB} + InputCarry;
`endif
                    m_sum  = '0;
                    m_cnt  = 0;
                    m_mode = 1;
                    n_accepts++;
                end
                1: begin
                    m_cnt++;
                    m_sum = m_full[TW-1:0] & TW'((m_one << (m_cnt * WW)) - 1);
                    if (m_cnt == WC) begin
                        m_cout = m_full[TW];
                        m_mode = 2;
                    end
                end
                default: if (OutReady) m_mode = 0;
            endcase
        end
    end

    always @(negedge Clock) begin
        if (ResetN) begin
            chk("in_ready",  InReady,     m_mode == 0);
            chk("out_valid", OutValid,    m_mode == 2);
            chk("busy",      Busy,        m_mode != 0);
            chk("sum",       Sum,         m_sum);
            chk("out_carry", OutputCarry, m_cout);
        end
    end

    task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin,
                          input logic [TW-1:0] es, input logic ec, input string nm);
        int lat;
        InputA = a; InputB = b; InputCarry = cin; InValid = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0; InputA = $urandom; InputB = $urandom; InputCarry = 1'b0;
        lat = 0;
        while (!OutValid && lat < 20) begin
            @(posedge Clock); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, WC);
        chk({nm, "_sum"}, Sum, es);
        chk({nm, "_carry"}, OutputCarry, ec);
        @(posedge Clock); #1;
    endtask

    initial begin
        #12;
        chk("reset_in_ready",  InReady,     1);
        chk("reset_out_valid", OutValid,    0);
        chk("reset_busy",      Busy,        0);
        chk("reset_sum",       Sum,         0);
        chk("reset_carry",     OutputCarry, 0);
        ResetN = 1'b1;
        @(posedge Clock); #1;

        s_a = 8'hF0; s_b = 8'h20; s_in_valid = 1'b1;
        @(posedge Clock); #1;
        s_in_valid = 1'b0;
        chk("single_valid_early", s_out_valid, 0);
        @(posedge Clock); #1;
        chk("single_valid", s_out_valid, 1);
        chk("single_sum",   s_sum,       8'h10);
        chk("single_carry", s_cout,      1);
        @(posedge Clock); #1;
        chk("single_ready", s_in_ready,  1);

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, "add_ff");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "chain");
        run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, "cin_only");

        // Back-pressure: result held while new requests are ignored.
        OutReady = 1'b0;
        InputA = 32'h0A0B_0C0D; InputB = 32'h0101_0101; InputCarry = 1'b0; InValid = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0;
        repeat (WC) begin @(posedge Clock); #1; end
        chk("bp_valid", OutValid, 1);
        for (int i = 0; i < 10; i++) begin
            InValid = 1'b1; InputA = $urandom; InputB = $urandom;
            @(posedge Clock); #1;
            chk("bp_sum",   Sum,         32'h0B0C_0D0E);
            chk("bp_carry", OutputCarry, 0);
            chk("bp_ready", InReady,     0);
        end
        InValid = 1'b0; OutReady = 1'b1;
        @(posedge Clock); #1;
        chk("bp_release", InReady, 1);

        // Reset while the third slice is pending.
        InputA = 32'hDEAD_BEEF; InputB = 32'h1357_9BDF; InValid = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0;
        repeat (2) begin @(posedge Clock); #1; end
        ResetN = 1'b0;
        #1;
        chk("mid_reset_valid", OutValid, 0);
        chk("mid_reset_sum",   Sum,      0);
        chk("mid_reset_ready", InReady,  1);
        @(negedge Clock); #1;
        ResetN = 1'b1;
        @(posedge Clock); #1;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, "after_reset");

`ifdef CLA_SEQ_SUBTRACT_EN
        Subtract = 1'b1;
        run_op(32'h0000_0010, 32'h0000_0020, 1'b1, 32'hFFFF_FFF0, 1'b0, "sub_neg");
        run_op(32'h0000_0020, 32'h0000_0010, 1'b0, 32'h0000_0010, 1'b1, "sub_pos");
        Subtract = 1'b0;
`endif

        begin
            int cyc;
            int start;
            cyc   = 0;
            start = n_accepts;
            while ((n_accepts - start) < 1000 && cyc < 30000) begin
                InValid    = ($urandom_range(0, 1) == 1);
                OutReady   = ($urandom_range(0, 3) != 0);
                InputA     = $urandom;
                InputB     = $urandom;
                InputCarry = ($urandom_range(0, 1) == 1);
`ifdef CLA_SEQ_SUBTRACT_EN
                Subtract   = ($urandom_range(0, 1) == 1);
`endif
                @(posedge Clock); #1;
                cyc++;
            end
            chk("random_ops_completed", (n_accepts - start) >= 1000, 1);
        end

        InValid = 1'b0; OutReady = 1'b1;
        repeat (WC + 3) begin @(posedge Clock); #1; end
        chk("final_idle", InReady, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
